// File: rtl/hazard_pkg.sv
// Shared encodings and FSM state type for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [7:0] WAIT_CNT_MAX = 8'd255;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-operand forwarding select: the M stage wins over W, and x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and memory-wait freeze.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN (MemErr is tied to 0 otherwise).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [7:0] WaitCnt,
  output logic       MemErr
);

  mem_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       lw_stall;
  logic       freeze;

  fwd_sel u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardBE)
  );

  assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign freeze   = MemReqM && !MemReadyM;

  // A freeze holds every stage and bubbles W; a pending branch waits until it ends.
  always_comb begin
    StallF = lw_stall && !PCSrcE;
    StallD = lw_stall && !PCSrcE;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = PCSrcE;
    FlushE = lw_stall || PCSrcE;
    FlushW = 1'b0;
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        if (freeze) begin
          if (wait_cnt_q != WAIT_CNT_MAX) wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign WaitCnt = wait_cnt_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  logic mem_err_q, mem_err_d;

  // The watchdog only reports; it never releases the freeze.
  always_comb begin
    mem_err_d = mem_err_q || ((state_q == WAIT) && (wait_cnt_q >= TIMEOUT_VAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end

  assign MemErr = mem_err_q;
`else
  assign MemErr = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps then randomized cycles against a
// behavioural model that tracks freeze run lengths rather than FSM state.
module tb_hazard_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       regWriteM;
    logic       regWriteW;
    logic [1:0] resultSrcE;
    logic       pcSrcE;
    logic       memReqM;
    logic       memReadyM;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [7:0] WaitCnt;

  int checks   = 0;
  int failures = 0;

  // Model: length of the current or last freeze run, whether last cycle froze, sticky error.
  int modelRunLen    = 0;
  bit modelPrevFreeze = 1'b0;
  bit modelErr       = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .WaitCnt(WaitCnt), .MemErr(MemErr)
  );

  task automatic checkVal(input string tag, input string name, input logic [7:0] obs,
                          input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", tag, name, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic applyStimulus(input stim_t s);
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E; RdE = s.rdE;
    RdM = s.rdM; RdW = s.rdW; RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    ResultSrcE = s.resultSrcE; PCSrcE = s.pcSrcE;
    MemReqM = s.memReqM; MemReadyM = s.memReadyM;
    #2;
  endtask

  task automatic checkOutput(input string tag);
    bit frz, lw;
    int expCnt;
    frz = MemReqM && !MemReadyM;
    lw  = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    expCnt = (modelRunLen > 255) ? 255 : modelRunLen;
    checkVal(tag, "ForwardAE", {6'd0, ForwardAE}, {6'd0, fwdModel(Rs1E)});
    checkVal(tag, "ForwardBE", {6'd0, ForwardBE}, {6'd0, fwdModel(Rs2E)});
    checkVal(tag, "StallF", {7'd0, StallF}, {7'd0, frz || (lw && !PCSrcE)});
    checkVal(tag, "StallD", {7'd0, StallD}, {7'd0, frz || (lw && !PCSrcE)});
    checkVal(tag, "StallE", {7'd0, StallE}, {7'd0, frz});
    checkVal(tag, "StallM", {7'd0, StallM}, {7'd0, frz});
    checkVal(tag, "FlushD", {7'd0, FlushD}, {7'd0, !frz && PCSrcE});
    checkVal(tag, "FlushE", {7'd0, FlushE}, {7'd0, !frz && (lw || PCSrcE)});
    checkVal(tag, "FlushW", {7'd0, FlushW}, {7'd0, frz});
    checkVal(tag, "WaitCnt", WaitCnt, 8'(expCnt));
    checkVal(tag, "MemErr", {7'd0, MemErr}, {7'd0, modelErr});
  endtask

  task automatic modelReset();
    modelRunLen = 0;
    modelPrevFreeze = 1'b0;
    modelErr = 1'b0;
  endtask

  // Advance one clock and update the model from the inputs sampled at that edge.
  task automatic tick();
    bit frz;
    @(posedge clk);
    frz = MemReqM && !MemReadyM;
    if (rst) begin
      modelReset();
    end else begin
`ifdef MEM_TIMEOUT_EN
      if (modelPrevFreeze && modelRunLen >= TO) modelErr = 1'b1;
`endif
      if (frz) modelRunLen = modelPrevFreeze ? modelRunLen + 1 : 1;
      modelPrevFreeze = frz;
    end
    #1;
  endtask

  task automatic step(input stim_t s, input string tag);
    applyStimulus(s);
    checkOutput(tag);
    tick();
  endtask

  task automatic resetPulse(input string tag);
    rst = 1'b1;
    #1;
    modelReset();
    checkVal(tag, "WaitCntAsyncRst", WaitCnt, 8'd0);
    checkVal(tag, "MemErrAsyncRst", {7'd0, MemErr}, 8'd0);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd7;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    rst = 1'b1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("reset");
    checkVal("reset", "WaitCntConst", WaitCnt, 8'd0);
    rst = 1'b0;
    tick();

    // Forwarding priority: M beats W, and RdM = 0 falls back to W.
    s = idle; s.rdM = 5; s.regWriteM = 1; s.rs1E = 5; s.rdW = 5; s.regWriteW = 1;
    applyStimulus(s); checkOutput("fwdMprio");
    checkVal("fwdMprio", "ForwardAEConst", {6'd0, ForwardAE}, 8'd2);
    tick();
    s.rdM = 0;
    applyStimulus(s); checkOutput("fwdW");
    checkVal("fwdW", "ForwardAEConst", {6'd0, ForwardAE}, 8'd1);
    tick();

    // Load-use stall for one cycle, then load forwarded from W.
    s = idle; s.resultSrcE = 2'b01; s.rdE = 7; s.rs2D = 7;
    applyStimulus(s); checkOutput("lwStall");
    checkVal("lwStall", "StallFConst", {7'd0, StallF}, 8'd1);
    checkVal("lwStall", "FlushEConst", {7'd0, FlushE}, 8'd1);
    tick();
    s = idle; s.rdM = 7; s.regWriteM = 1;
    applyStimulus(s); checkOutput("lwBubble");
    checkVal("lwBubble", "StallFConst", {7'd0, StallF}, 8'd0);
    tick();
    s = idle; s.rdW = 7; s.regWriteW = 1; s.rs2E = 7;
    step(s, "lwFwdW");
    s = idle; s.resultSrcE = 2'b01; s.rdE = 0; s.rs2D = 0;
    applyStimulus(s); checkOutput("lwRd0");
    checkVal("lwRd0", "StallFConst", {7'd0, StallF}, 8'd0);
    tick();

    // Branch overrides load-use stall.
    s = idle; s.resultSrcE = 2'b01; s.rdE = 7; s.rs1D = 7; s.pcSrcE = 1;
    applyStimulus(s); checkOutput("branch");
    checkVal("branch", "StallDConst", {7'd0, StallD}, 8'd0);
    checkVal("branch", "FlushDConst", {7'd0, FlushD}, 8'd1);
    tick();

    // Request completing immediately causes no freeze.
    s = idle; s.memReqM = 1; s.memReadyM = 1;
    applyStimulus(s); checkOutput("memFast");
    checkVal("memFast", "StallMConst", {7'd0, StallM}, 8'd0);
    tick();
    applyStimulus(idle); checkOutput("memFastAfter");
    checkVal("memFastAfter", "WaitCntConst", WaitCnt, 8'd0);
    tick();

    // Three-cycle freeze with a branch pending underneath.
    s = idle; s.memReqM = 1; s.memReadyM = 0; s.pcSrcE = 1;
    for (int i = 0; i < 3; i++) step(s, "freeze3");
    s.memReadyM = 1;
    applyStimulus(s); checkOutput("freeze3End");
    checkVal("freeze3End", "WaitCntConst", WaitCnt, 8'd3);
    checkVal("freeze3End", "FlushDConst", {7'd0, FlushD}, 8'd1);
    tick();
    step(idle, "freeze3Hold");

    // Reset in the second cycle of a wait aborts it.
    s = idle; s.memReqM = 1; s.memReadyM = 0;
    step(s, "rstMid1");
    applyStimulus(s); checkOutput("rstMid2");
    resetPulse("rstMid2");
    tick();
    s.memReadyM = 1;
    step(s, "rstMidEnd");
    step(idle, "rstMidIdle");

    // Long freeze: saturation and watchdog behaviour.
    s = idle; s.memReqM = 1; s.memReadyM = 0;
    for (int i = 0; i < 260; i++) step(s, "longFreeze");
    s.memReadyM = 1;
    applyStimulus(s); checkOutput("longEnd");
    checkVal("longEnd", "WaitCntSat", WaitCnt, 8'd255);
`ifdef MEM_TIMEOUT_EN
    checkVal("longEnd", "MemErrConst", {7'd0, MemErr}, 8'd1);
`else
    checkVal("longEnd", "MemErrConst", {7'd0, MemErr}, 8'd0);
`endif
    tick();
    for (int i = 0; i < 3; i++) step(idle, "longSticky");
    resetPulse("postLong");
    tick();

    // Randomized cycles with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      s.rs1D = pickReg(); s.rs2D = pickReg(); s.rs1E = pickReg(); s.rs2E = pickReg();
      s.rdE = pickReg(); s.rdM = pickReg(); s.rdW = pickReg();
      s.regWriteM = 1'($urandom_range(0, 1));
      s.regWriteW = 1'($urandom_range(0, 1));
      s.resultSrcE = 2'($urandom_range(0, 3));
      s.pcSrcE = ($urandom_range(0, 4) == 0);
      s.memReqM = 1'($urandom_range(0, 1));
      s.memReadyM = ($urandom_range(0, 9) < 3);
      applyStimulus(s);
      checkOutput("random");
      if ($urandom_range(0, 199) == 0) resetPulse("randomRst");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
